// File: rtl/ram_ctrl_8x16_pkg.sv
// rtl/ram_ctrl_8x16_pkg.sv - shared widths, opcodes and FSM state encoding
// Purpose: common definitions for the 8x16 RAM controller and its memory.
// Ports: none (package).
package ram_ctrl_8x16_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_8x16.sv
// rtl/ram_8x16.sv - 8-word x 16-bit RAM with synchronous write, combinational read
// Purpose: memory driven by ram_ctrl_8x16.
// Ports: i_clk clock; i_cs chip select; i_rw 1=write 0=read; i_addr word address;
//        i_din write data; o_dout read data (0 when not selected).
module ram_8x16
  import ram_ctrl_8x16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_cs,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clk) begin
    if (i_cs && i_rw) begin
      r_mem[i_addr] <= i_din;
    end
  end

  assign o_dout = i_cs ? r_mem[i_addr] : '0;

endmodule

// File: rtl/ram_ctrl_8x16.sv
// rtl/ram_ctrl_8x16.sv - request/response controller for an 8x16 RAM
// Purpose: accepts read/write/fill requests, drives the RAM strobes and returns
//          one response per request; opcode 11 answers with an error flag only.
// Ports: clk, rst (sync, active-high);
//        req_valid/req_ready/req_op/req_addr/req_wdata request channel;
//        resp_valid/resp_ready/resp_rdata/resp_err response channel;
//        mem_cs/mem_rw/mem_addr/mem_din to RAM, mem_dout from RAM.
module ram_ctrl_8x16
  import ram_ctrl_8x16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_cs,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              w_accept;
  logic              w_mem_cs;
  logic              w_mem_rw;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_din;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  always_comb begin
    w_next     = r_state;
    w_mem_cs   = 1'b0;
    w_mem_rw   = 1'b0;
    w_mem_din  = '0;
    w_mem_addr = r_mem_addr;  // address bus holds its last value when idle
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_READ:  w_next = ST_READ;
            OP_WRITE: w_next = ST_WRITE;
            OP_FILL:  w_next = ST_FILL;
            default:  w_next = ST_RESP;
          endcase
        end
      end
      ST_READ: begin
        w_mem_cs   = 1'b1;
        w_mem_addr = r_addr;
        w_next     = ST_RESP;
      end
      ST_WRITE: begin
        w_mem_cs   = 1'b1;
        w_mem_rw   = 1'b1;
        w_mem_addr = r_addr;
        w_mem_din  = r_wdata;
        w_next     = ST_RESP;
      end
      ST_FILL: begin
        w_mem_cs   = 1'b1;
        w_mem_rw   = 1'b1;
        w_mem_addr = r_cnt;
        w_mem_din  = r_wdata;
        if (r_cnt == ADDR_W'(7)) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_READ;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_next;
      r_mem_addr <= w_mem_addr;
      if (w_accept) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= '0;
        r_rdata <= '0;  // non-read responses carry zero data
      end
      if (r_state == ST_READ) begin
        r_rdata <= mem_dout;
      end
      if (r_state == ST_FILL) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  // The latched opcode is cleared on reset, so this reads 0 until a reserved op arrives.
  assign resp_err   = (r_op == OP_RSVD);
  assign mem_cs     = w_mem_cs;
  assign mem_rw     = w_mem_rw;
  assign mem_addr   = w_mem_addr;
  assign mem_din    = w_mem_din;

endmodule

// File: tb/tb_ram_ctrl_8x16.sv
// tb/tb_ram_ctrl_8x16.sv - scoreboard testbench for ram_ctrl_8x16
module tb_ram_ctrl_8x16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_cs;
  logic        mem_rw;
  logic [2:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  always #5 clk = ~clk;

  ram_ctrl_8x16 u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_cs    (mem_cs),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  ram_8x16 u_ram (
    .i_clk (clk),
    .i_cs  (mem_cs),
    .i_rw  (mem_rw),
    .i_addr(mem_addr),
    .i_din (mem_din),
    .o_dout(mem_dout)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: pops one expectation per response and checks it every RESP cycle.
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   in_resp = 0;
  bit   pend_idle = 0;
  exp_t cur;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_resp   = 0;
      pend_idle = 0;
    end else begin
      if (pend_idle) begin
        check("idle_after_resp", {30'd0, req_ready, resp_valid}, 32'b10);
        pend_idle = 0;
      end
      if (req_valid && req_ready) acc_cyc = cyc;
      if (resp_valid) begin
        if (!in_resp) begin
          if (q.size() == 0) begin
            timeout_fail("unexpected_resp");
            cur = '{16'h0, 1'b0, 0};
          end else begin
            cur = q.pop_front();
            check("resp_latency", cyc - acc_cyc, cur.lat);
          end
          in_resp = 1;
        end
        check("resp_rdata", resp_rdata, cur.rdata);
        check("resp_err", resp_err, cur.err);
        check("req_ready_in_resp", req_ready, 0);
        if (resp_ready) begin
          in_resp   = 0;
          pend_idle = 1;
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] addr, input logic [15:0] wd);
    bit ok = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail("accept");
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Junk on the request bus while busy must have no effect.
    req_op    = ~op;
    req_addr  = ~addr;
    req_wdata = ~wd;
  endtask

  task automatic wait_idle(output bit cs_seen);
    bit ok = 0;
    cs_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_cs) cs_seen = 1;
      if (req_ready && !resp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail("wait_idle");
  endtask

  task automatic txn(input logic [1:0] op, input logic [2:0] addr, input logic [15:0] wd,
                     input logic [15:0] exp_rd, input logic exp_err, input int lat,
                     output bit cs_seen);
    q.push_back('{exp_rd, exp_err, lat});
    send(op, addr, wd);
    wait_idle(cs_seen);
  endtask

  task automatic fill_checked(input logic [15:0] wd);
    bit cs;
    q.push_back('{16'h0000, 1'b0, 9});
    send(2'b10, 3'd5, wd);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("fill_mem_addr", mem_addr, i);
      check("fill_strobe", {mem_cs, mem_rw, mem_din}, {2'b11, wd});
    end
    wait_idle(cs);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {req_ready, resp_valid, resp_rdata, resp_err, mem_cs, mem_rw, mem_addr, mem_din},
          {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0});
  endtask

  initial begin
    bit cs;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = 3'd0;
    req_wdata  = 16'h0;
    resp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset_idle");

    // Clear memory, then write/read round trip.
    fill_checked(16'h0000);
    txn(2'b01, 3'd6, 16'hABCD, 16'h0000, 1'b0, 2, cs);
    txn(2'b00, 3'd6, 16'h0000, 16'hABCD, 1'b0, 2, cs);

    // Fill pattern then read every word.
    fill_checked(16'h5A5A);
    for (int a = 0; a < 8; a++) begin
      txn(2'b00, 3'(a), 16'h0000, 16'h5A5A, 1'b0, 2, cs);
    end

    // Reserved opcode: error, no memory access, contents untouched.
    txn(2'b11, 3'd3, 16'h1111, 16'h0000, 1'b1, 1, cs);
    check("rsvd_no_cs", cs, 0);
    txn(2'b00, 3'd3, 16'h0000, 16'h5A5A, 1'b0, 2, cs);

    // Response back-pressure: resp_ready low for 5 RESP cycles.
    txn(2'b01, 3'd2, 16'h1234, 16'h0000, 1'b0, 2, cs);
    resp_ready = 1'b0;
    q.push_back('{16'h1234, 1'b0, 2});
    send(2'b00, 3'd2, 16'h0000);
    begin
      bit ok = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (resp_valid) begin
          ok = 1;
          break;
        end
      end
      if (!ok) timeout_fail("hold_resp_valid");
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_req_ready", req_ready, 0);
      check("hold_resp_valid", resp_valid, 1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_idle(cs);

    // Reset in the 4th cycle of a fill: words 0..3 written, 4..7 untouched.
    fill_checked(16'h0000);
    send(2'b10, 3'd0, 16'hFFFF);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle_after_mid_fill_reset");
    for (int a = 0; a < 8; a++) begin
      txn(2'b00, 3'(a), 16'h0000, (a < 4) ? 16'hFFFF : 16'h0000, 1'b0, 2, cs);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    tests_failed++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1);
  end

endmodule

// File: doc/ram_ctrl_8x16.md
RAM_CTRL_8X16 -- requirements
Module: ram_ctrl_8x16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 is the sole clock, with all state updated on its rising edge; rst input 1 is synchronous and active-high.
REQ-002 req_valid  input  1  host request present.
REQ-003 req_ready  output  1  controller can accept a request.
REQ-004 req_op  input  2  opcode: 00 read, 01 write, 10 fill, 11 reserved.
REQ-005 req_addr  input  3  word address 0..7.
REQ-006 req_wdata  input  16  write/fill data.
REQ-007 resp_valid  output  1  response present.
REQ-008 resp_ready  input  1  host accepts response.
REQ-009 resp_rdata  output  16  read data; 16'h0000 for write/fill/reserved.
REQ-010 resp_err  output  1  reserved opcode flag.
REQ-011 mem_cs  output  1  RAM chip select.
REQ-012 mem_rw  output  1  RAM write enable (1 write, 0 read).
REQ-013 mem_addr  output  3  RAM address.
REQ-014 mem_din  output  16  data to RAM.
REQ-015 mem_dout  input  16  RAM data, combinational from mem_addr while mem_cs=1.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, WRITE, FILL and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1, and op, addr and wdata SHALL be latched at that edge.
REQ-018 IDLE SHALL transition by accepted op: 00->READ, 01->WRITE, 10->FILL, 11->RESP with resp_err=1 and no memory access.
REQ-019 READ SHALL last one cycle with mem_cs=1, mem_rw=0 and mem_addr=latched addr; mem_dout SHALL be captured into resp_rdata at the end of that cycle; the next state SHALL be RESP.
REQ-020 WRITE SHALL last one cycle with mem_cs=1, mem_rw=1, mem_addr=addr and mem_din=wdata; the next state SHALL be RESP.
REQ-021 FILL SHALL last exactly 8 cycles with mem_cs=1, mem_rw=1 and mem_din=wdata, and a 3-bit counter SHALL drive mem_addr 0,1,...,7 in that order regardless of req_addr; after the cycle with count 7 the next state SHALL be RESP.
REQ-022 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until an edge with resp_ready=1, then the FSM SHALL return to IDLE.
REQ-023 Latency from accept edge to resp_valid=1: read/write 2 cycles, fill 9 cycles, reserved 1 cycle.
REQ-024 Outside READ, WRITE and FILL, mem_cs and mem_rw SHALL be 0, mem_din SHALL be 0, and mem_addr SHALL hold its last value.
REQ-025 A new request SHALL NOT be accepted in the same cycle as a response handshake; req_ready SHALL rise the cycle after RESP exits.
REQ-026 req_op, req_addr and req_wdata SHALL be ignored while req_ready=0.
REQ-027 resp_err SHALL be 0 for every non-reserved op.

Reset
REQ-028 With rst=1 at an edge, the state SHALL become IDLE and all outputs SHALL be 0 in the following cycle (req_ready=1 excepted), including mid-FILL or mid-RESP.
REQ-029 A memory write strobed in the cycle during which rst is sampled SHALL still commit at that edge, and no further strobes SHALL follow.
REQ-030 The fill counter, latched op/addr/wdata, resp_rdata and resp_err SHALL all clear to 0 on reset.

Structure
REQ-031 A shared package SHALL hold the opcode constants OP_READ/OP_WRITE/OP_FILL/OP_RSVD, the state encoding, and the widths ADDR_W=3 and DATA_W=16.
REQ-032 The block SHALL be a single FSM module with no sub-modules; the bench SHALL instantiate the existing ram_8x16 as the memory model.

Verification
REQ-033 Write addr 6 data 16'hABCD, then read addr 6 -> read resp_rdata=16'hABCD with resp_err=0, and resp_valid 2 cycles after each accept.
REQ-034 Fill 16'h5A5A, then read addresses 0..7 -> every read returns 16'h5A5A; mem_addr sequence 0..7 observed over 8 consecutive cycles; response 9 cycles after accept.
REQ-035 Op 11 at addr 3 -> resp_err=1, resp_rdata=0, mem_cs never asserted, and memory contents unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles after a read of addr 2 (data 16'h1234) -> resp_valid and resp_rdata stay stable; req_ready=0 throughout; IDLE is entered the cycle after resp_ready=1.
REQ-037 Assert rst during cycle 4 of a fill of 16'hFFFF over prior contents 0 -> addresses 0..3 read 16'hFFFF and 4..7 read 0; all outputs idle the cycle after reset.
